// File: rtl/btw_pkg.sv
// -----------------------------------------------------------------------------
// btw_pkg
// Shared definitions for the byte_to_word assembler and its idle timer.
//
// Contents:
//   state_t             - assembler states B0..B3 (Bn = n bytes held).
//   LANE_W / WORD_W     - byte lane width and assembled word width.
//   BTW_TIMEOUT_DEFAULT - default number of idle cycles that abort a partial
//                         word (only meaningful when BTW_TIMEOUT_EN is defined).
//   idle_cnt_width()    - counter width able to hold 0..timeout.
// -----------------------------------------------------------------------------
package btw_pkg;

    localparam int LANE_W              = 8;
    localparam int WORD_W              = 32;
    localparam int LANES               = WORD_W / LANE_W;
    localparam int BTW_TIMEOUT_DEFAULT = 8;

    // The encoding is chosen so the state value is directly the count of
    // bytes already captured; byte_idx is driven straight from it.
    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } state_t;

    // Width of a counter that must reach 'timeout'; never less than one bit.
    function automatic int idle_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : btw_pkg

// File: rtl/btw_idle_timer.sv
// -----------------------------------------------------------------------------
// btw_idle_timer
// Counts consecutive cycles in which 'run' is high. 'expire' is raised
// combinationally on the cycle whose rising edge would bring the count to
// TIMEOUT, so the owner can act on that same edge. The count returns to zero
// whenever 'run' drops or on expiry.
//
// Ports:
//   clk_4f  in   byte-rate clock, rising edge
//   reset   in   asynchronous, active-high reset
//   run     in   an idle cycle is in progress while a partial word is held
//   expire  out  this edge completes TIMEOUT consecutive idle cycles
//   count   out  current number of consecutive idle cycles (observability)
// -----------------------------------------------------------------------------
module btw_idle_timer
    import btw_pkg::*;
#(
    parameter int TIMEOUT = BTW_TIMEOUT_DEFAULT,
    parameter int CNT_W   = idle_cnt_width(TIMEOUT)
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             run,
    output logic             expire,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    assign expire = run && (count == LAST);

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule : btw_idle_timer

// File: rtl/byte_to_word.sv
// -----------------------------------------------------------------------------
// byte_to_word
// Assembles a stream of bytes (most-significant byte first) into 32-bit words.
// Each fourth valid byte completes a word: data_out is loaded and valid_out
// pulses for one cycle. Idle cycles (valid_in=0) simply hold everything.
//
// Optional feature, macro BTW_TIMEOUT_EN:
//   When defined, TIMEOUT consecutive idle cycles while a partial word is held
//   discard that partial word and pulse frame_err for one cycle. When not
//   defined, frame_err is constant 0 and partial words wait indefinitely.
//
// Handshake: valid_in qualifies data_in on each rising edge; there is no
// back-pressure, so every cycle with valid_in=1 consumes one byte. valid_out
// is a one-cycle pulse with no ready; data_out stays stable until the next
// completed word.
//
// Ports:
//   clk_4f     in   byte-rate clock, rising edge
//   reset      in   asynchronous, active-high reset
//   valid_in   in   data_in carries a byte this cycle
//   data_in    in   [7:0] byte stream, MSB-first per word
//   valid_out  out  one-cycle pulse, data_out holds a new word
//   data_out   out  [31:0] last assembled word
//   byte_idx   out  [1:0] bytes of the current partial word held (FSM state)
//   frame_err  out  one-cycle pulse when a partial word times out
// -----------------------------------------------------------------------------
module byte_to_word
    import btw_pkg::*;
#(
    parameter int TIMEOUT = BTW_TIMEOUT_DEFAULT
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [LANE_W-1:0] data_in,
    output logic              valid_out,
    output logic [WORD_W-1:0] data_out,
    output logic [1:0]        byte_idx,
    output logic              frame_err
);

    // A timeout shorter than one idle cycle has no meaning.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("byte_to_word: TIMEOUT must be at least 1");
    end

    state_t            state;
    logic [LANE_W-1:0] lane3;
    logic [LANE_W-1:0] lane2;
    logic [LANE_W-1:0] lane1;
    logic              timeout_fire;

    // The state register itself is the exposed byte count.
    assign byte_idx = state;

`ifdef BTW_TIMEOUT_EN
    logic                                idle_run;
    logic [idle_cnt_width(TIMEOUT)-1:0]  idle_count;

    // Idle cycles only count while a partial word is held; a valid byte
    // drops 'run' and therefore clears the counter, so a timeout can never
    // coincide with a captured byte.
    assign idle_run = !valid_in && (state != B0);

    btw_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .run     (idle_run),
        .expire  (timeout_fire),
        .count   (idle_count)
    );
`else
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state     <= B0;
            lane3     <= '0;
            lane2     <= '0;
            lane1     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Both output flags are pulses; they default low every cycle.
            valid_out <= 1'b0;
            frame_err <= 1'b0;

            if (valid_in) begin
                unique case (state)
                    B0: begin
                        lane3 <= data_in;
                        state <= B1;
                    end
                    B1: begin
                        lane2 <= data_in;
                        state <= B2;
                    end
                    B2: begin
                        lane1 <= data_in;
                        state <= B3;
                    end
                    B3: begin
                        // Lane 0 is never stored: the 4th byte goes straight
                        // into the word so it is visible one cycle later.
                        data_out  <= {lane3, lane2, lane1, data_in};
                        valid_out <= 1'b1;
                        state     <= B0;
                    end
                    default: begin
                        state <= B0;
                    end
                endcase
            end else if (timeout_fire) begin
                // Discard the partial word; data_out keeps the last good word.
                state     <= B0;
                lane3     <= '0;
                lane2     <= '0;
                lane1     <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule : byte_to_word

// File: tb/tb_byte_to_word.sv
module tb_byte_to_word;
    import btw_pkg::*;

    localparam int TIMEOUT = 8;

    // ---------------- clock / reset ----------------
    logic        clk_4f = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [1:0]  byte_idx;
    logic        frame_err;

    always #5 clk_4f = ~clk_4f;

    byte_to_word #(.TIMEOUT(TIMEOUT)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .byte_idx  (byte_idx),
        .frame_err (frame_err)
    );

    // ---------------- reference model / scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          ferr_count = 0;
    logic [7:0]  partial[$];      // bytes of the word being assembled
    logic [31:0] exp_q[$];        // completed words awaiting valid_out
    int          pulse_cyc[$];
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_ferr;
    int          idle_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_reset();
        partial.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        idle_cnt  = 0;
    endtask

    // Effect of one rising edge with the given inputs.
    task automatic model_edge(input logic v, input logic [7:0] d);
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (v) begin
            partial.push_back(d);
            idle_cnt = 0;
            if (partial.size() == 4) begin
                exp_data  = {partial[0], partial[1], partial[2], partial[3]};
                exp_valid = 1'b1;
                exp_q.push_back(exp_data);
                partial.delete();
            end
        end
`ifdef BTW_TIMEOUT_EN
        else if (partial.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) begin
                partial.delete();
                idle_cnt = 0;
                exp_ferr = 1'b1;
            end
        end
`endif
    endtask

    task automatic check_outputs();
        check_eq("byte_idx", 32'(byte_idx), 32'(partial.size()));
        check_eq("valid_out", 32'(valid_out), 32'(exp_valid));
        check_eq("frame_err", 32'(frame_err), 32'(exp_ferr));
        check_eq("data_out", data_out, exp_data);
        check_eq("exclusive", 32'(valid_out & frame_err), 32'd0);
        if (valid_out) begin
            pulse_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", data_out, 32'hxxxxxxxx);
            end else begin
                check_eq("sb_word", data_out, exp_q.pop_front());
            end
        end
        if (frame_err) ferr_count++;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives, clocks, then checks at the next fall.
    task automatic step(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        model_edge(v, d);
        cycle++;
        @(negedge clk_4f);
        check_outputs();
    endtask

    task automatic async_reset(input string tag);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq({tag, "_idx"}, 32'(byte_idx), 32'd0);
        check_eq({tag, "_data"}, data_out, 32'd0);
        check_eq({tag, "_vout"}, 32'(valid_out), 32'd0);
        check_eq({tag, "_ferr"}, 32'(frame_err), 32'd0);
        @(negedge clk_4f);
        reset = 1'b0;
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] b;
    int         idx_seq[7];

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk_4f);
        check_eq("reset_idx", 32'(byte_idx), 32'd0);
        check_eq("reset_data", data_out, 32'd0);
        check_eq("reset_vout", 32'(valid_out), 32'd0);
        check_eq("reset_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;

        // Continuous bytes, one word.
        step(1, 8'hFF); step(1, 8'hFB); step(1, 8'hBF); step(1, 8'hFF);
        check_eq("r025_data", data_out, 32'hFFFBBFFF);
        check_eq("r025_vout", 32'(valid_out), 32'd1);
        step(0, 8'h00);
        check_eq("r025_pulse_len", 32'(valid_out), 32'd0);

        // Back-to-back words.
        pulse_cyc.delete();
        repeat (4) step(1, 8'hDD);
        check_eq("r026_word1", data_out, 32'hDDDDDDDD);
        step(1, 8'h00); step(1, 8'h00); step(1, 8'h00); step(1, 8'h03);
        check_eq("r026_word2", data_out, 32'h00000003);
        check_eq("r026_pulses", 32'(pulse_cyc.size()), 32'd2);
        if (pulse_cyc.size() == 2)
            check_eq("r026_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);

        // Mid-word gap with garbage on data_in.
        idx_seq = '{1, 2, 2, 2, 2, 3, 0};
        check_eq("r027_idx0", 32'(byte_idx), 32'd0);
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 1 || i == 5 || i == 6) step(1, 8'hAA);
            else                                       step(0, 8'h55);
            check_eq("r027_idx", 32'(byte_idx), 32'(idx_seq[i]));
        end
        check_eq("r027_data", data_out, 32'hAAAAAAAA);

        // Asynchronous reset mid-word.
        step(1, 8'h9A); step(1, 8'hBC);
        async_reset("r028_rst");
        step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44);
        check_eq("r028_data", data_out, 32'h11223344);

        ferr_count = 0;
`ifdef BTW_TIMEOUT_EN
        // One idle short of the limit must not abort.
        step(1, 8'hA1);
        repeat (TIMEOUT - 1) step(0, 8'h00);
        step(1, 8'hA2); step(1, 8'hA3); step(1, 8'hA4);
        check_eq("to_edge_data", data_out, 32'hA1A2A3A4);
        check_eq("to_edge_ferr", 32'(ferr_count), 32'd0);
        step(1, 8'h12);
        repeat (TIMEOUT) step(0, 8'h00);
        check_eq("r029_ferr", 32'(frame_err), 32'd1);
        check_eq("r029_idx", 32'(byte_idx), 32'd0);
        step(0, 8'h00);
        check_eq("r029_ferr_once", 32'(ferr_count), 32'd1);
        step(1, 8'h01); step(1, 8'h02); step(1, 8'h03); step(1, 8'h04);
        check_eq("r029_data", data_out, 32'h01020304);
`else
        step(1, 8'h12);
        repeat (20) step(0, 8'h00);
        check_eq("r030_idx", 32'(byte_idx), 32'd1);
        step(1, 8'h34); step(1, 8'h56); step(1, 8'h78);
        check_eq("r030_data", data_out, 32'h12345678);
        check_eq("r030_ferr", 32'(ferr_count), 32'd0);
`endif

        // Randomized traffic: bursts, gaps around the timeout, rare resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd_rst");
            end else if ($urandom_range(0, 19) == 0) begin
                int gap;
                gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                for (int g = 0; g < gap; g++) begin
                    b = 8'($urandom);
                    step(0, b);
                end
            end else begin
                b = 8'($urandom);
                step($urandom_range(0, 3) != 0, b);
            end
        end

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_byte_to_word

// File: doc/byte_to_word.md
BYTE_TO_WORD -- requirements
Module: byte_to_word

Interface
REQ-001 Parameter: TIMEOUT, default 8, consecutive idle cycles that abort a partial word (used only with BTW_TIMEOUT_EN).
REQ-002 Port: clk_4f  input  1  byte-rate clock; all logic on rising edge.
REQ-003 Port: reset  input  1  reset; asynchronous, active-high.
REQ-004 Port: valid_in  input  1  data_in carries a valid byte this cycle.
REQ-005 Port: data_in  input  8  byte stream, most-significant byte of each word first.
REQ-006 Port: valid_out  output  1  one-cycle pulse; data_out holds a newly completed word.
REQ-007 Port: data_out  output  32  last assembled word.
REQ-008 Port: byte_idx  output  2  number of bytes of the current partial word already captured (0-3).
REQ-009 Port: frame_err  output  1  one-cycle pulse when a partial word is discarded by timeout.

Function
REQ-010 The block SHALL have four states, B0 through B3, where Bn means n bytes are held; byte_idx SHALL equal n.
REQ-011 When valid_in=1 on a rising edge in Bn (n<3), the block SHALL store data_in in byte lane 3-n and advance to Bn+1.
REQ-012 When valid_in=1 on a rising edge in B3, the block SHALL load data_out with {lane3, lane2, lane1, data_in}, assert valid_out for exactly the following cycle, and return to B0.
REQ-013 Latency: valid_out SHALL be high in the cycle immediately after the edge that samples the 4th valid byte.
REQ-014 Back-to-back operation SHALL need no idle cycles; continuous valid bytes SHALL give one valid_out pulse every 4 cycles.
REQ-015 When valid_in=0, the block SHALL hold its state, lanes and data_out; gaps mid-word SHALL NOT corrupt or abort assembly (subject to REQ-020).
REQ-016 data_out SHALL hold its value between pulses; it SHALL change only on the edge that sets valid_out.
REQ-017 data_in SHALL be ignored whenever valid_in=0, including X values.
REQ-018 valid_out and frame_err SHALL never be high at the same time.

Reset
REQ-019 While reset=1, the block SHALL force state B0, byte_idx=0, data_out=32'h0, valid_out=0, frame_err=0, all lanes=0, and idle counter=0, immediately and independent of clk_4f; a partial word in progress SHALL be discarded without frame_err.

Configuration
REQ-020 With BTW_TIMEOUT_EN defined, the block SHALL count consecutive valid_in=0 cycles in B1-B3; on reaching TIMEOUT it SHALL discard the partial word, return to B0 and pulse frame_err for one cycle; any valid byte SHALL clear the counter.
REQ-021 Without BTW_TIMEOUT_EN, there SHALL be no idle counter, frame_err SHALL be tied to 0, and partial words SHALL wait indefinitely.
REQ-022 In B0 the idle counter SHALL NOT run; a timeout SHALL NOT fire on the same edge as a valid byte.

Structure
REQ-023 A shared package/header btw_pkg SHALL hold the state encodings (B0-B3), the lane width (8), the word width (32) and the TIMEOUT default.
REQ-024 The idle counter SHALL be a separate sub-module, btw_idle_timer, instantiated only under BTW_TIMEOUT_EN; everything else SHALL be in byte_to_word.

Verification
REQ-025 Continuous bytes FF,FB,BF,FF with valid_in=1 -> one cycle later data_out=32'hFFFBBFFF, valid_out=1 for exactly 1 cycle.
REQ-026 Bytes DD x4 followed directly by 00,00,00,03 -> pulses exactly 4 cycles apart; data_out=32'hDDDDDDDD, then 32'h00000003.
REQ-027 Bytes AA,AA, then valid_in=0 for 3 cycles with data_in=8'h55, then AA,AA -> data_out=32'hAAAAAAAA; byte_idx sequence 0,1,2,2,2,2,3,0.
REQ-028 Reset asserted asynchronously after 2 bytes of a word -> immediately byte_idx=0, data_out=0; the next 4 bytes 11,22,33,44 -> 32'h11223344.
REQ-029 With BTW_TIMEOUT_EN and TIMEOUT=8: byte 12, then 8 idle cycles -> frame_err pulses once, byte_idx=0; then 01,02,03,04 -> 32'h01020304.
REQ-030 Without BTW_TIMEOUT_EN: byte 12, then 20 idle cycles, then 34,56,78 -> data_out=32'h12345678 and frame_err is never asserted.
